// File: rtl/instr_fetch_buffer_if.sv
// Handshake bundle between instruction fetch, the fetch buffer and decode.
// master = fetch/decode side driving the buffer; slave = the buffer itself.
interface instr_fetch_buffer_if #(
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [15:0]     out_imm16;
  logic [PC_W-1:0] out_pc;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_imm16, out_pc
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rs, out_rt, out_imm16, out_pc
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Elastic in-order instruction queue between fetch and decode, splitting the head word into fields.
// Optional FETCH_STATS_EN adds stat_issued / stat_stall counters.
//
// state      | meaning
// ST_EMPTY   | no entries, out_valid low, out fields zero
// ST_PARTIAL | 1..DEPTH-1 entries, can push and pop
// ST_FULL    | DEPTH entries, in_ready low
module instr_fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_buffer_if.slave   bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stall
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [AW-1:0]   rd_ptr, rd_next;
  logic [AW-1:0]   wr_ptr, wr_next;
  logic [AW:0]     count, count_next;

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];

  logic            push;
  logic            pop;
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;

  assign bus.in_ready  = (state != ST_FULL);
  assign bus.out_valid = (state != ST_EMPTY);

  // Flush wins over both sides of the handshake; the offered word is dropped.
  assign push = bus.in_valid  & bus.in_ready  & ~bus.flush;
  assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EMPTY;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      rd_ptr <= rd_next;
      wr_ptr <= wr_next;
      count  <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    rd_next    = rd_ptr;
    wr_next    = wr_ptr;
    count_next = count;
    if (bus.flush) begin
      state_next = ST_EMPTY;
      rd_next    = '0;
      wr_next    = '0;
      count_next = '0;
    end else begin
      if (push) wr_next = wr_ptr + 1'b1;
      if (pop)  rd_next = rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
      case (state)
        ST_EMPTY: begin
          if (push) state_next = ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (push && !pop && (count == CNT_LAST))
            state_next = ST_FULL;
          else if (pop && !push && (count == CNT_ONE))
            state_next = ST_EMPTY;
        end
        ST_FULL: begin
          // push is blocked while full, so any pop drains one slot
          if (pop) state_next = ST_PARTIAL;
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= bus.in_instr;
      mem_pc[wr_ptr]    <= bus.in_pc;
    end
  end

  // Zero the head fields when empty so stale storage never reaches decode.
  assign head_instr = bus.out_valid ? mem_instr[rd_ptr] : 32'd0;
  assign head_pc    = bus.out_valid ? mem_pc[rd_ptr]    : '0;

  assign bus.out_opcode = head_instr[31:26];
  assign bus.out_rs     = head_instr[25:21];
  assign bus.out_rt     = head_instr[20:16];
  assign bus.out_imm16  = head_instr[15:0];
  assign bus.out_pc     = head_pc;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (pop) stat_issued <= stat_issued + 32'd1;
      if (bus.out_valid && !bus.out_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer (DEPTH=2), including FETCH_STATS_EN counters when defined.
module tb_instr_fetch_buffer;
  localparam int PC_W = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instr_fetch_buffer_if #(.PC_W(PC_W)) bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  instr_fetch_buffer #(.DEPTH(2), .PC_W(PC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave)
`ifdef FETCH_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] instr, input logic [31:0] pc);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_word"}, 64'({bus.out_opcode, bus.out_rs, bus.out_rt, bus.out_imm16}), 64'(instr));
    chk({tag, "_pc"}, 64'(bus.out_pc), 64'(pc));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_imm16", 64'(bus.out_imm16), 64'd0);
    chk("rst_pc", 64'(bus.out_pc), 64'd0);
    step();
    rst = 1'b0;
    step();

    // single word and field split
    drive(1'b1, 32'h2C22FFF6, 32'h40, 1'b0, 1'b0);
    #1;
    chk("single_no_bypass", 64'(bus.out_valid), 64'd0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("single_opcode", 64'(bus.out_opcode), 64'h0B);
    chk("single_rs", 64'(bus.out_rs), 64'd1);
    chk("single_rt", 64'(bus.out_rt), 64'd2);
    chk("single_imm16", 64'(bus.out_imm16), 64'hFFF6);
    chk("single_pc", 64'(bus.out_pc), 64'h40);
    step();
    chk("single_held", 64'(bus.out_imm16), 64'hFFF6);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    chk("single_drained", 64'(bus.out_valid), 64'd0);
    chk("single_zero_imm", 64'(bus.out_imm16), 64'd0);
    chk("single_zero_pc", 64'(bus.out_pc), 64'd0);

    // fill to full, third word held back by the source
    drive(1'b1, 32'h8C430010, 32'h100, 1'b0, 1'b0);
    step();
    chk("fill1_in_ready", 64'(bus.in_ready), 64'd1);
    chk_head("fill1_head", 32'h8C430010, 32'h100);
    drive(1'b1, 32'hAC641234, 32'h104, 1'b0, 1'b0);
    step();
    chk("fill2_in_ready", 64'(bus.in_ready), 64'd0);
    chk_head("fill2_head", 32'h8C430010, 32'h100);
    drive(1'b1, 32'h1085FF00, 32'h108, 1'b0, 1'b0);
    step();
    chk("fill3_blocked", 64'(bus.in_ready), 64'd0);
    chk_head("fill3_head", 32'h8C430010, 32'h100);
    drive(1'b1, 32'h1085FF00, 32'h108, 1'b1, 1'b0);
    step();
    chk("fill_pop1_ready", 64'(bus.in_ready), 64'd1);
    chk_head("fill_pop1", 32'hAC641234, 32'h104);
    step();
    chk_head("fill_pop2", 32'h1085FF00, 32'h108);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    chk("fill_empty", 64'(bus.out_valid), 64'd0);

    // streaming push+pop every cycle, pointers wrap repeatedly
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h20000000 | 32'(i), 32'(4 * i), 1'b1, 1'b0);
      step();
      chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
      chk_head("stream_head", 32'h20000000 | 32'(i), 32'(4 * i));
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    chk("stream_drained", 64'(bus.out_valid), 64'd0);

    // flush with two queued, offered word and ready both asserted
    drive(1'b1, 32'h11110001, 32'h200, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h11110002, 32'h204, 1'b0, 1'b0);
    step();
    chk("flush_pre_full", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'hDEADBEEF, 32'h208, 1'b1, 1'b1);
    step();
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_pc_zero", 64'(bus.out_pc), 64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    chk("flush_dropped", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 32'h22220003, 32'h300, 1'b0, 1'b0);
    step();
    chk_head("flush_after", 32'h22220003, 32'h300);

    // async reset mid-stream with two entries queued
    drive(1'b1, 32'h22220004, 32'h304, 1'b0, 1'b0);
    step();
    chk("midrst_pre_full", 64'(bus.in_ready), 64'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_imm16", 64'(bus.out_imm16), 64'd0);
`ifdef FETCH_STATS_EN
    chk("midrst_stat_issued", 64'(stat_issued), 64'd0);
    chk("midrst_stat_stall", 64'(stat_stall), 64'd0);
`endif
    step();
    rst = 1'b0;
    step();

`ifdef FETCH_STATS_EN
    // 3 stall cycles then 5 pops, then a flush that must not touch the counters
    drive(1'b1, 32'h33330001, 32'h400, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h33330002, 32'h404, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    step();
    chk("stats_stall3", 64'(stat_stall), 64'd3);
    chk("stats_issued0", 64'(stat_issued), 64'd0);
    drive(1'b1, 32'h33330003, 32'h408, 1'b1, 1'b0);
    step();
    step();
    drive(1'b1, 32'h33330004, 32'h40C, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h33330005, 32'h410, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    step();
    chk("stats_empty", 64'(bus.out_valid), 64'd0);
    chk("stats_issued5", 64'(stat_issued), 64'd5);
    chk("stats_stall_kept", 64'(stat_stall), 64'd3);
    drive(1'b1, 32'h33330006, 32'h414, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stats_flush_issued", 64'(stat_issued), 64'd5);
    chk("stats_flush_stall", 64'(stat_stall), 64'd3);
    chk("stats_flush_empty", 64'(bus.out_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
